// File: rtl/usb_flex_sr_rx.sv
// Serial-in/parallel-out receive shift register with bit counter and word-complete pulse.
// Latency: 1 cycle from a sampled shift_enable to parallel_out/bit_count/word_done.
// No backpressure: a bit is taken on every cycle shift_enable is high; clear overrides it.
//
// Ports:
//   clk, n_rst    clock (rising edge) and async active-low reset
//   shift_enable  capture serial_in this cycle
//   serial_in     decoded, de-stuffed data bit
//   clear         sync clear: register <= RESET_VAL, count <= 0
//   parallel_out  current register contents
//   bit_count     bits shifted since last wrap/clear
//   word_done     1-cycle pulse after the NUM_BITS-th bit of a word is captured
module usb_flex_sr_rx #(
  parameter int                    NUM_BITS  = 8,
  parameter int                    SHIFT_MSB = 0,
  parameter logic [NUM_BITS-1:0]   RESET_VAL = '1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          shift_enable,
  input  logic                          serial_in,
  input  logic                          clear,
  output logic [NUM_BITS-1:0]           parallel_out,
  output logic [$clog2(NUM_BITS+1)-1:0] bit_count,
  output logic                          word_done
);

  localparam int CW = $clog2(NUM_BITS + 1);

  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q   <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clear) begin
      // clear wins over a same-cycle shift: the bit is dropped and no pulse is raised
      sr_d  = RESET_VAL;
      cnt_d = '0;
    end else if (shift_enable) begin
      if (SHIFT_MSB != 0) begin
        sr_d = {sr_q[NUM_BITS-2:0], serial_in};
      end else begin
        // USB is LSB-first: new bits enter at the top and walk down to bit 0
        sr_d = {serial_in, sr_q[NUM_BITS-1:1]};
      end
      // the count wraps on the bit that completes the word, so it never reads NUM_BITS
      if (cnt_q == CW'(NUM_BITS - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign parallel_out = sr_q;
  assign bit_count    = cnt_q;
  assign word_done    = done_q;

endmodule

// File: tb/tb_usb_flex_sr_rx.sv
module tb_usb_flex_sr_rx;

  logic       clk;
  logic       n_rst;
  logic       se8, si8, clr8;
  logic [7:0] po8;
  logic [3:0] bc8;
  logic       wd8;
  logic       se4, si4, clr4;
  logic [3:0] po4;
  logic [2:0] bc4;
  logic       wd4;

  int checks;
  int errors;

  usb_flex_sr_rx #(.NUM_BITS(8), .SHIFT_MSB(0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(se8), .serial_in(si8), .clear(clr8),
    .parallel_out(po8), .bit_count(bc8), .word_done(wd8)
  );

  usb_flex_sr_rx #(.NUM_BITS(4), .SHIFT_MSB(1)) u_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(se4), .serial_in(si4), .clear(clr4),
    .parallel_out(po4), .bit_count(bc4), .word_done(wd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a negedge; outputs are sampled on the following negedge.
  task automatic step8(input logic se, input logic si, input logic cl);
    se8 = se; si8 = si; clr8 = cl;
    @(negedge clk);
  endtask

  task automatic step4(input logic se, input logic si);
    se4 = se; si4 = si; clr4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    se8 = 0; si8 = 0; clr8 = 0; se4 = 0; si4 = 0; clr4 = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (po8 !== 8'hFF || bc8 !== 4'd0 || wd8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_in po=%h bc=%0d wd=%b exp po=ff bc=0 wd=0", po8, bc8, wd8);
    end
    checks++;
    if (po4 !== 4'hF || bc4 !== 3'd0 || wd4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_in4 po=%h bc=%0d wd=%b exp po=f bc=0 wd=0", po4, bc4, wd4);
    end
    n_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step8(1'b0, 1'b0, 1'b0);
      checks++;
      if (po8 !== 8'hFF || bc8 !== 4'd0 || wd8 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle%0d po=%h bc=%0d wd=%b exp po=ff bc=0 wd=0", i, po8, bc8, wd8);
      end
    end
  endtask

  task automatic test_lsb_byte;
    logic [7:0] b;
    b = 8'h9A;
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, b[i], 1'b0);
      checks++;
      if (bc8 !== 4'((i + 1) % 8) || wd8 !== (i == 7)) begin
        errors++;
        $display("FAIL lsb_shift%0d bc=%0d wd=%b exp bc=%0d wd=%b", i, bc8, wd8, (i + 1) % 8, i == 7);
      end
    end
    checks++;
    if (po8 !== 8'h9A) begin
      errors++;
      $display("FAIL lsb_byte po=%h exp 9a", po8);
    end
    step8(1'b0, 1'b0, 1'b0);
    checks++;
    if (wd8 !== 1'b0 || po8 !== 8'h9A) begin
      errors++;
      $display("FAIL lsb_pulse_end wd=%b po=%h exp wd=0 po=9a", wd8, po8);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      step8(1'b0, 1'(i & 1), 1'b0);
      checks++;
      if (po8 !== 8'h9A || bc8 !== 4'd0 || wd8 !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d po=%h bc=%0d wd=%b exp po=9a bc=0 wd=0", i, po8, bc8, wd8);
      end
    end
  endtask

  task automatic test_clear_priority;
    step8(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step8(1'b1, 1'b0, 1'b0);
    checks++;
    if (po8 !== 8'h1F || bc8 !== 4'd3) begin
      errors++;
      $display("FAIL clear_pre po=%h bc=%0d exp po=1f bc=3", po8, bc8);
    end
    step8(1'b1, 1'b0, 1'b1);
    checks++;
    if (po8 !== 8'hFF || bc8 !== 4'd0 || wd8 !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio po=%h bc=%0d wd=%b exp po=ff bc=0 wd=0", po8, bc8, wd8);
    end
    step8(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    logic [7:0] b;
    for (int i = 0; i < 5; i++) step8(1'b1, 1'b0, 1'b0);
    checks++;
    if (po8 !== 8'h07 || bc8 !== 4'd5) begin
      errors++;
      $display("FAIL areset_pre po=%h bc=%0d exp po=07 bc=5", po8, bc8);
    end
    se8 = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (po8 !== 8'hFF || bc8 !== 4'd0 || wd8 !== 1'b0) begin
      errors++;
      $display("FAIL areset_now po=%h bc=%0d wd=%b exp po=ff bc=0 wd=0", po8, bc8, wd8);
    end
    @(negedge clk);
    n_rst = 1'b1;
    b = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, b[i], 1'b0);
      checks++;
      if (bc8 !== 4'((i + 1) % 8) || wd8 !== (i == 7)) begin
        errors++;
        $display("FAIL areset_shift%0d bc=%0d wd=%b exp bc=%0d wd=%b", i, bc8, wd8, (i + 1) % 8, i == 7);
      end
    end
    checks++;
    if (po8 !== 8'hA5) begin
      errors++;
      $display("FAIL areset_byte po=%h exp a5", po8);
    end
    step8(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [3:0] bits;
    logic [3:0] exp_po [8];
    logic [2:0] exp_bc [8];
    // word 1: 1,0,1,1 -> B ; word 2 straight after: 0,1,0,0 -> 4
    exp_po = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h6, 4'hD, 4'hA, 4'h4};
    exp_bc = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step4(1'b1, bits[i]);
      checks++;
      if (po4 !== exp_po[i] || bc4 !== exp_bc[i] || wd4 !== (i == 3)) begin
        errors++;
        $display("FAIL msb4_w1_%0d po=%h bc=%0d wd=%b exp po=%h bc=%0d wd=%b",
                 i, po4, bc4, wd4, exp_po[i], exp_bc[i], i == 3);
      end
    end
    bits = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step4(1'b1, bits[i]);
      checks++;
      if (po4 !== exp_po[i+4] || bc4 !== exp_bc[i+4] || wd4 !== (i == 3)) begin
        errors++;
        $display("FAIL msb4_w2_%0d po=%h bc=%0d wd=%b exp po=%h bc=%0d wd=%b",
                 i, po4, bc4, wd4, exp_po[i+4], exp_bc[i+4], i == 3);
      end
    end
    step4(1'b0, 1'b1);
    checks++;
    if (po4 !== 4'h4 || wd4 !== 1'b0) begin
      errors++;
      $display("FAIL msb4_hold po=%h wd=%b exp po=4 wd=0", po4, wd4);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lsb_byte();
    test_hold();
    test_clear_priority();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
